// File: rtl/mc_ctrl.sv
// mc_ctrl
//   Multi-cycle control FSM for the single-issue MIPS subset datapath.
//   Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB. It leaves early
//   once its path is complete. Opcode and funct are captured from the
//   instruction memory on the edge that leaves FETCH. The later states are then
//   decoded from that captured copy.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high
//   instr     in   32     instruction memory output, sampled only in FETCH
//   zero      in   1      ALU equality flag, consulted only in EXEC of beq
//   PCWr      out  1      PC write strobe
//   NPCOp     out  2      next-PC select: 00 PC+4, 01 branch, 10 jump
//   IRWr      out  1      instruction-register write strobe
//   RFWr      out  1      register-file write strobe
//   RegDst    out  1      destination register: 0 rt, 1 rd
//   ALUSrc    out  1      ALU B operand: 0 rt data, 1 extender output
//   ALUOp     out  2      00 add, 01 sub, 10 or
//   EOp       out  2      00 sign-ext, 01 zero-ext, 10 imm<<16, 11 sign-ext<<2
//   DMWr      out  1      data-memory write strobe
//   MemtoReg  out  1      write-back source: 0 ALU result, 1 DM data
//   retired   out  CNT_W  count of completed instructions (wraps)

module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             PCWr,
  output logic [1:0]       NPCOp,
  output logic             IRWr,
  output logic             RFWr,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       EOp,
  output logic             DMWr,
  output logic             MemtoReg,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J
  } iclass_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  iclass_t    cls;
  logic [1:0] dec_aluop;
  logic [1:0] dec_eop;
  logic       done;

  // Only opcode and funct steer the controller. The register and immediate
  // fields go straight to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  // Classify the captured instruction. Also work out the ALU and extender
  // settings it uses. Unrecognised encodings fall through as nop.
  always_comb begin
    cls       = C_NOP;
    dec_aluop = 2'b00;
    dec_eop   = 2'b00;
    case (op_q)
      6'b000000: begin
        if (funct_q == 6'b100001) begin
          cls = C_ADDU;
        end else if (funct_q == 6'b100011) begin
          cls       = C_SUBU;
          dec_aluop = 2'b01;
        end
      end
      6'b001101: begin
        cls       = C_ORI;
        dec_aluop = 2'b10;
        dec_eop   = 2'b01;
      end
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: begin
        cls       = C_BEQ;
        dec_aluop = 2'b01;
        dec_eop   = 2'b11;
      end
      6'b001111: begin
        cls     = C_LUI;
        dec_eop = 2'b10;
      end
      6'b000010: cls = C_J;
      default: ;
    endcase
  end

  // Next-state logic. 'done' marks the final state of the current path. That
  // state returns to FETCH and retires the instruction on the same edge.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        op_d    = instr[31:26];
        funct_d = instr[5:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_J || cls == C_NOP) done = 1'b1;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW:                   state_d = S_MEM;
          default:                      done = 1'b1;
        endcase
      end
      S_MEM: begin
        if (cls == C_LW) state_d = S_WB;
        else             done = 1'b1;
      end
      S_WB:    done = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (done) state_d = S_FETCH;
    retired_d = done ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  // Output decode. The outputs depend on the state and the captured
  // instruction; the only exception is PCWr in beq EXEC, which follows zero.
  // Reset masks every strobe, so an aborted instruction leaves no side effect.
  always_comb begin
    PCWr     = 1'b0;
    NPCOp    = 2'b00;
    IRWr     = 1'b0;
    RFWr     = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    EOp      = 2'b00;
    DMWr     = 1'b0;
    MemtoReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_DECODE: begin
        if (cls == C_J) begin
          PCWr  = 1'b1;
          NPCOp = 2'b10;
        end
      end
      S_EXEC: begin
        ALUOp = dec_aluop;
        EOp   = dec_eop;
        case (cls)
          C_ADDU, C_SUBU:             RegDst = 1'b1;
          C_ORI, C_LUI, C_LW, C_SW:   ALUSrc = 1'b1;
          C_BEQ: begin
            NPCOp = 2'b01;
            PCWr  = zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUOp = dec_aluop;
        EOp   = dec_eop;
        DMWr  = (cls == C_SW);
      end
      S_WB: begin
        ALUOp    = dec_aluop;
        EOp      = dec_eop;
        RFWr     = 1'b1;
        RegDst   = (cls == C_ADDU || cls == C_SUBU);
        MemtoReg = (cls == C_LW);
      end
      default: ;
    endcase
    if (reset) begin
      PCWr = 1'b0;
      IRWr = 1'b0;
      RFWr = 1'b0;
      DMWr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl
//   Self-checking bench for mc_ctrl. Each instruction issued pushes one
//   expected control vector per cycle of its path, plus the expected retired
//   count, into a scoreboard queue. Every cycle, the test tasks pop an entry
//   and compare it with the sampled DUT outputs.
//   Control vector bit order:
//   {PCWr, NPCOp[1:0], IRWr, RFWr, RegDst, ALUSrc, ALUOp[1:0], EOp[1:0], DMWr, MemtoReg}

module tb_mc_ctrl;

  typedef struct packed {
    logic [12:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        PCWr;
  logic [1:0]  NPCOp;
  logic        IRWr;
  logic        RFWr;
  logic        RegDst;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [1:0]  EOp;
  logic        DMWr;
  logic        MemtoReg;
  logic [31:0] retired;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_ret = 32'd0;
  exp_t        sb[$];

  mc_ctrl #(.CNT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .zero     (zero),
    .PCWr     (PCWr),
    .NPCOp    (NPCOp),
    .IRWr     (IRWr),
    .RFWr     (RFWr),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .ALUOp    (ALUOp),
    .EOp      (EOp),
    .DMWr     (DMWr),
    .MemtoReg (MemtoReg),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops a hung run, but only after printing a failure line.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [12:0] pk(input logic pcwr, input logic [1:0] npc,
                                     input logic irwr, input logic rfwr,
                                     input logic regdst, input logic alusrc,
                                     input logic [1:0] aluop, input logic [1:0] eop,
                                     input logic dmwr, input logic m2r);
    return {pcwr, npc, irwr, rfwr, regdst, alusrc, aluop, eop, dmwr, m2r};
  endfunction

  task automatic push_vec(input logic [12:0] v);
    exp_t e;
    e.ctrl = v;
    e.ret  = model_ret;
    sb.push_back(e);
  endtask

  // Reference table: the control vectors expected for each cycle of each
  // instruction type.
  task automatic push_instr(input logic [31:0] ins, input logic zb, output int n);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [12:0] f_v;
    logic [12:0] idle;
    op   = ins[31:26];
    fn   = ins[5:0];
    f_v  = pk(1, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    idle = 13'd0;
    push_vec(f_v);
    if (op == 6'h00 && fn == 6'h21) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
      push_vec(pk(0, 2'b00, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));
      n = 4;
    end else if (op == 6'h00 && fn == 6'h23) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0));
      push_vec(pk(0, 2'b00, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0));
      n = 4;
    end else if (op == 6'h0D) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b01, 0, 0));
      push_vec(pk(0, 2'b00, 0, 1, 0, 0, 2'b10, 2'b01, 0, 0));
      n = 4;
    end else if (op == 6'h0F) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0));
      push_vec(pk(0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0));
      n = 4;
    end else if (op == 6'h23) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1));
      n = 5;
    end else if (op == 6'h2B) begin
      push_vec(idle);
      push_vec(pk(0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
      push_vec(pk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
      n = 4;
    end else if (op == 6'h04) begin
      push_vec(idle);
      push_vec(pk(zb, 2'b01, 0, 0, 0, 0, 2'b01, 2'b11, 0, 0));
      n = 3;
    end else if (op == 6'h02) begin
      push_vec(pk(1, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      n = 2;
    end else begin
      push_vec(idle);
      n = 2;
    end
    model_ret = model_ret + 32'd1;
  endtask

  // Drives one cycle and samples the outputs at mid-cycle. instr carries the
  // real word only in the FETCH cycle and garbage otherwise. zero carries the
  // requested value only in cycle 2 and is random otherwise.
  task automatic step(input int c, input logic [31:0] ins, input logic zb,
                      output logic [12:0] obs, output logic [31:0] ret);
    instr = (c == 0) ? ins : $urandom();
    zero  = (c == 2) ? zb : 1'($urandom_range(0, 1));
    @(negedge clk);
    obs = {PCWr, NPCOp, IRWr, RFWr, RegDst, ALUSrc, ALUOp, EOp, DMWr, MemtoReg};
    ret = retired;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] obs;
    logic [31:0] ret;
    reset = 1'b1;
    instr = 32'h3C011234;
    zero  = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      step(0, 32'h3C011234, 1'b1, obs, ret);
      checks++;
      if ({obs[12], obs[9], obs[8], obs[1]} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_strobes cyc%0d got=%b exp=0000", c, {obs[12], obs[9], obs[8], obs[1]});
      end
      checks++;
      if (ret !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_retired got=%0d exp=0", ret);
      end
    end
    reset     = 1'b0;
    model_ret = 32'd0;
  endtask

  task automatic test_lui;
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    push_instr(32'h3C011234, 1'b0, n);
    for (int c = 0; c < n; c++) begin
      step(c, 32'h3C011234, 1'b0, obs, ret);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl) begin
        failures++;
        $display("[TB] FAIL lui_ctrl cyc%0d got=%b exp=%b", c, obs, e.ctrl);
      end
      checks++;
      if (ret !== e.ret) begin
        failures++;
        $display("[TB] FAIL lui_retired cyc%0d got=%0d exp=%0d", c, ret, e.ret);
      end
    end
  endtask

  task automatic test_alu;
    logic [31:0] prog [3] = '{32'h34220005, 32'h00221821, 32'h00221823};
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    for (int i = 0; i < 3; i++) begin
      push_instr(prog[i], 1'b0, n);
      for (int c = 0; c < n; c++) begin
        step(c, prog[i], 1'b0, obs, ret);
        e = sb.pop_front();
        checks++;
        if (obs !== e.ctrl || ret !== e.ret) begin
          failures++;
          $display("[TB] FAIL alu_%08h cyc%0d got=%b/%0d exp=%b/%0d", prog[i], c, obs, ret, e.ctrl, e.ret);
        end
      end
    end
  endtask

  task automatic test_mem;
    logic [31:0] prog [2] = '{32'h8C030004, 32'hAC030008};
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    for (int i = 0; i < 2; i++) begin
      push_instr(prog[i], 1'b0, n);
      for (int c = 0; c < n; c++) begin
        step(c, prog[i], 1'b0, obs, ret);
        e = sb.pop_front();
        checks++;
        if (obs !== e.ctrl || ret !== e.ret) begin
          failures++;
          $display("[TB] FAIL mem_%08h cyc%0d got=%b/%0d exp=%b/%0d", prog[i], c, obs, ret, e.ctrl, e.ret);
        end
      end
    end
  endtask

  task automatic test_beq;
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    for (int z = 1; z >= 0; z--) begin
      push_instr(32'h10220003, 1'(z), n);
      for (int c = 0; c < n; c++) begin
        step(c, 32'h10220003, 1'(z), obs, ret);
        e = sb.pop_front();
        checks++;
        if (obs !== e.ctrl || ret !== e.ret) begin
          failures++;
          $display("[TB] FAIL beq_z%0d cyc%0d got=%b/%0d exp=%b/%0d", z, c, obs, ret, e.ctrl, e.ret);
        end
      end
    end
  endtask

  task automatic test_jump_nop;
    logic [31:0] prog [4] = '{32'h08000010, 32'h00000000, 32'h00221820, 32'hFC000000};
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    for (int i = 0; i < 4; i++) begin
      push_instr(prog[i], 1'b0, n);
      for (int c = 0; c < n; c++) begin
        step(c, prog[i], 1'b0, obs, ret);
        e = sb.pop_front();
        checks++;
        if (obs !== e.ctrl || ret !== e.ret) begin
          failures++;
          $display("[TB] FAIL jnop_%08h cyc%0d got=%b/%0d exp=%b/%0d", prog[i], c, obs, ret, e.ctrl, e.ret);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog [9] = '{32'h3C011234, 32'h34220005, 32'h00221821, 32'h00221823,
                              32'h8C030004, 32'hAC030008, 32'h10220003, 32'h08000010,
                              32'h00000000};
    logic [31:0] ins;
    logic        zb;
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    for (int i = 0; i < 30; i++) begin
      ins = prog[$urandom_range(0, 8)];
      zb  = 1'($urandom_range(0, 1));
      push_instr(ins, zb, n);
      for (int c = 0; c < n; c++) begin
        step(c, ins, zb, obs, ret);
        e = sb.pop_front();
        checks++;
        if (obs !== e.ctrl || ret !== e.ret) begin
          failures++;
          $display("[TB] FAIL b2b_%0d_%08h cyc%0d got=%b/%0d exp=%b/%0d", i, ins, c, obs, ret, e.ctrl, e.ret);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int          n;
    exp_t        e;
    logic [12:0] obs;
    logic [31:0] ret;
    // lw aborted in MEM: its WB entry never happens and the count is cleared.
    push_instr(32'h8C030004, 1'b0, n);
    void'(sb.pop_back());
    for (int c = 0; c < 4; c++) begin
      if (c == 3) reset = 1'b1;
      step(c, 32'h8C030004, 1'b0, obs, ret);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || ret !== e.ret) begin
        failures++;
        $display("[TB] FAIL rstmid_lw cyc%0d got=%b/%0d exp=%b/%0d", c, obs, ret, e.ctrl, e.ret);
      end
    end
    reset     = 1'b0;
    model_ret = 32'd0;
    push_instr(32'h3C011234, 1'b0, n);
    for (int c = 0; c < n; c++) begin
      step(c, 32'h3C011234, 1'b0, obs, ret);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || ret !== e.ret) begin
        failures++;
        $display("[TB] FAIL rstmid_lui cyc%0d got=%b/%0d exp=%b/%0d", c, obs, ret, e.ctrl, e.ret);
      end
    end
    // Reset held through a FETCH cycle must mask IRWr and PCWr.
    reset = 1'b1;
    push_vec(13'd0);
    step(0, 32'h3C011234, 1'b0, obs, ret);
    e = sb.pop_front();
    checks++;
    if (obs !== e.ctrl || ret !== e.ret) begin
      failures++;
      $display("[TB] FAIL rst_in_fetch got=%b/%0d exp=%b/%0d", obs, ret, e.ctrl, e.ret);
    end
    reset     = 1'b0;
    model_ret = 32'd0;
    push_instr(32'h00000000, 1'b0, n);
    for (int c = 0; c < n; c++) begin
      step(c, 32'h00000000, 1'b0, obs, ret);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctrl || ret !== e.ret) begin
        failures++;
        $display("[TB] FAIL rst_after_nop cyc%0d got=%b/%0d exp=%b/%0d", c, obs, ret, e.ctrl, e.ret);
      end
    end
    @(negedge clk);
    checks++;
    if (retired !== model_ret) begin
      failures++;
      $display("[TB] FAIL final_retired got=%0d exp=%0d", retired, model_ret);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    zero  = 1'b0;
    test_reset();
    test_lui();
    test_alu();
    test_mem();
    test_beq();
    test_jump_nop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
